round_sequencer: RTL and testbench
==================================

// Module: round_sequencer
// PURPOSE
//  Game-round controller for the number ticker. It sequences one round at a time:
//  - clears and runs the 0..MAX_COUNT number counter on divider ticks;
//  - programs the speed select of the rate-divider bank;
//  - captures the number when the player presses stop, and scores it against a target.
//  It escalates speed per round and ends the game on ROUNDS hits (win) or LIVES misses (lose).
// PARAMETERS
//  MAX_COUNT      100         last counter value; next tick after MAX_COUNT wraps to 0
//  ROUNDS         8           hits needed to win (1..15)
//  LIVES          3           misses allowed before loss (1..3)
//  TOLERANCE      2           hit if |captured - target| <= TOLERANCE
//  RESULT_CYCLES  25000000    CLOCK_50 cycles spent showing the result before next round
// PORTS
//  CLOCK_50        in   1  system clock, all logic on posedge
//  reset           in   1  synchronous, active-high; forces IDLE
//  start           in   1  one-cycle pulse; starts a game from IDLE or OVER
//  stop_btn        in   1  one-cycle pulse (pre-debounced); player stop request
//  tick            in   1  one-cycle enable from divider bank, at rate chosen by speed_sel
//  target          in   7  value the player aims for, sampled in CHECK
//  speed_sel       out  3  divider select: 1=1s, 2=0.5s, 3=0.25s, 4=0.1s per tick
//  current_number  out  7  live counter value
//  captured        out  7  counter value latched on stop
//  hit             out  1  last scored round was a hit (valid in RESULT/OVER)
//  round           out  4  hits so far this game
//  lives           out  2  misses remaining
//  busy            out  1  high in ARM, RUN, CHECK, RESULT
//  done            out  1  high in OVER
//  win             out  1  valid with done: 1=all rounds hit, 0=lives exhausted
// BEHAVIOUR
//  Reset: state=IDLE, speed_sel=1, current_number=0, captured=0, hit=0, round=0,
//   lives=LIVES, busy=0, done=0, win=0. Reset mid-round abandons the round, with no scoring.
//  States:
//  - IDLE: start -> ARM; round<=0, lives<=LIVES.
//  - ARM (1 cycle): current_number<=0; speed_sel<=(round>=3)?4:round+1 -> RUN.
//  - RUN: tick increments current_number; at MAX_COUNT a tick wraps it to 0.
//    Ticks count only in RUN. stop_btn -> CHECK; captured<=current_number as
//    registered that cycle (tick in the same cycle is ignored, no increment).
//  - CHECK (1 cycle): compute the 8-bit unsigned |captured-target|; hit<=(diff<=TOLERANCE).
//    - Hit: round<=round+1; if round+1==ROUNDS -> OVER with win<=1, else -> RESULT.
//    - Miss: lives<=lives-1; if lives==1 -> OVER with win<=0, else -> RESULT.
//  - RESULT: counter frozen; wait exactly RESULT_CYCLES cycles, then -> ARM.
//  - OVER: done=1; counter frozen; speed_sel<=1; start -> ARM with round<=0,
//    lives<=LIVES, hit<=0.
//  Pulse handling:
//  - start is ignored outside IDLE/OVER.
//  - stop_btn is ignored outside RUN.
//  - If start and stop_btn arrive in the same cycle, each is judged against the current state.
//  Outputs are registered. busy/done decode from state with no extra latency.
//  Latency: stop_btn at cycle N -> captured valid N+1, hit/round/lives valid N+2.
// TESTING (bench overrides RESULT_CYCLES=4, MAX_COUNT=10; tick every 3rd cycle)
//  1. reset 2 cycles, then idle -> speed_sel=1, lives=3, busy=0, done=0, current_number=0.
//  2. start; 5 ticks; stop_btn; target=5 -> captured=5, hit=1, round=1;
//     after 4 cycles ARM then speed_sel=2, current_number=0.
//  3. Run 11 ticks -> current_number goes 10 then 0 (wrap); stop at 0, target=9 ->
//     diff 9, hit=0, lives=2.
//  4. Three misses in a row from lives=3 -> done=1, win=0, lives=0, busy=0;
//     further stop_btn has no effect.
//  5. With ROUNDS=2, two hits (target=captured+2 then captured-2) -> done=1, win=1;
//     speed_sel on round 2 = 2. Then start -> round=0, lives=3, busy=1.
//  6. tick and stop_btn in the same cycle at value 7 -> captured=7.
//     reset asserted during RUN -> next cycle IDLE, all reset values.

Source files
------------

// File: rtl/round_sequencer.sv
// Game-round controller for the number ticker: runs the counter, sets divider speed,
// captures on stop, scores against a target and tracks hits/misses until win or loss.
//
// state  | meaning
// IDLE   | waiting for start after reset
// ARM    | clear counter, program speed for this round (1 cycle)
// RUN    | counter advances on ticks, waiting for stop
// CHECK  | score captured value against target (1 cycle)
// RESULT | counter frozen while the result is shown
// OVER   | game finished, win flag valid, waiting for start
module round_sequencer #(
  parameter int MAX_COUNT     = 100,
  parameter int ROUNDS        = 8,
  parameter int LIVES         = 3,
  parameter int TOLERANCE     = 2,
  parameter int RESULT_CYCLES = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       stop_btn,
  input  logic       tick,
  input  logic [6:0] target,
  output logic [2:0] speed_sel,
  output logic [6:0] current_number,
  output logic [6:0] captured,
  output logic       hit,
  output logic [3:0] round,
  output logic [1:0] lives,
  output logic       busy,
  output logic       done,
  output logic       win
);

  localparam int TW = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(RESULT_CYCLES - 1);
  localparam logic [6:0] MAX7   = 7'(MAX_COUNT);
  localparam logic [7:0] TOL8   = 8'(TOLERANCE);
  localparam logic [3:0] ROUND4 = 4'(ROUNDS);
  localparam logic [1:0] LIVES2 = 2'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_CHECK,
    S_RESULT,
    S_OVER
  } state_t;

  state_t          r_state;
  logic [2:0]      r_speed;
  logic [6:0]      r_number;
  logic [6:0]      r_captured;
  logic            r_hit;
  logic [3:0]      r_round;
  logic [1:0]      r_lives;
  logic            r_win;
  logic [TW-1:0]   r_timer;

  logic [6:0]      w_number_inc;
  logic [7:0]      w_diff;
  logic            w_hit;
  logic [3:0]      w_round_inc;
  logic [2:0]      w_speed_next;

  assign w_number_inc = (r_number == MAX7) ? 7'd0 : r_number + 7'd1;
  assign w_diff       = (r_captured >= target) ? {1'b0, r_captured - target}
                                               : {1'b0, target - r_captured};
  assign w_hit        = (w_diff <= TOL8);
  assign w_round_inc  = r_round + 4'd1;
  // Speed escalates one step per hit and saturates at the fastest rate from round 3 on.
  assign w_speed_next = (r_round >= 4'd3) ? 3'd4 : (r_round[2:0] + 3'd1);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_speed    <= 3'd1;
      r_number   <= 7'd0;
      r_captured <= 7'd0;
      r_hit      <= 1'b0;
      r_round    <= 4'd0;
      r_lives    <= LIVES2;
      r_win      <= 1'b0;
      r_timer    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_round <= 4'd0;
            r_lives <= LIVES2;
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          r_number <= 7'd0;
          r_speed  <= w_speed_next;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          // Stop wins over a coincident tick so the player gets the value they saw.
          if (stop_btn) begin
            r_captured <= r_number;
            r_state    <= S_CHECK;
          end else if (tick) begin
            r_number <= w_number_inc;
          end
        end
        S_CHECK: begin
          r_hit <= w_hit;
          if (w_hit) begin
            r_round <= w_round_inc;
            if (w_round_inc == ROUND4) begin
              r_win   <= 1'b1;
              r_state <= S_OVER;
            end else begin
              r_timer <= TIMER_LOAD;
              r_state <= S_RESULT;
            end
          end else begin
            r_lives <= r_lives - 2'd1;
            if (r_lives == 2'd1) begin
              r_win   <= 1'b0;
              r_state <= S_OVER;
            end else begin
              r_timer <= TIMER_LOAD;
              r_state <= S_RESULT;
            end
          end
        end
        S_RESULT: begin
          if (r_timer == '0) begin
            r_state <= S_ARM;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_OVER: begin
          r_speed <= 3'd1;
          if (start) begin
            r_round <= 4'd0;
            r_lives <= LIVES2;
            r_hit   <= 1'b0;
            r_state <= S_ARM;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign speed_sel      = r_speed;
  assign current_number = r_number;
  assign captured       = r_captured;
  assign hit            = r_hit;
  assign round          = r_round;
  assign lives          = r_lives;
  assign win            = r_win;
  assign busy           = (r_state == S_ARM) || (r_state == S_RUN) ||
                          (r_state == S_CHECK) || (r_state == S_RESULT);
  assign done           = (r_state == S_OVER);

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: round-level reference model of scoring, lives,
// speed escalation and game end, driven with directed and randomized rounds.
module tb_round_sequencer;

  localparam int MAXC   = 10;
  localparam int NROUND = 4;
  localparam int NLIVES = 3;
  localparam int TOL    = 2;
  localparam int RCYC   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop_btn = 1'b0;
  logic       tick = 1'b0;
  logic [6:0] target = 7'd0;
  logic [2:0] speed_sel;
  logic [6:0] current_number;
  logic [6:0] captured;
  logic       hit;
  logic [3:0] round;
  logic [1:0] lives;
  logic       busy;
  logic       done;
  logic       win;

  round_sequencer #(
    .MAX_COUNT(MAXC), .ROUNDS(NROUND), .LIVES(NLIVES),
    .TOLERANCE(TOL), .RESULT_CYCLES(RCYC)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .stop_btn(stop_btn),
    .tick(tick), .target(target), .speed_sel(speed_sel),
    .current_number(current_number), .captured(captured), .hit(hit),
    .round(round), .lives(lives), .busy(busy), .done(done), .win(win)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game state as the player would describe it.
  int m_round, m_lives, m_cap;
  bit m_hit, m_win, m_over;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit t, input bit s, input bit st);
    tick = t; stop_btn = s; start = st;
    @(posedge clk);
    #1;
    tick = 1'b0; stop_btn = 1'b0; start = 1'b0;
  endtask

  function automatic int exp_speed();
    return (m_round >= 3) ? 4 : m_round + 1;
  endfunction

  task automatic check_reset_vals();
    check_eq("rst_speed",   speed_sel, 1);
    check_eq("rst_number",  current_number, 0);
    check_eq("rst_capt",    captured, 0);
    check_eq("rst_hit",     hit, 0);
    check_eq("rst_round",   round, 0);
    check_eq("rst_lives",   lives, NLIVES);
    check_eq("rst_busy",    busy, 0);
    check_eq("rst_done",    done, 0);
    check_eq("rst_win",     win, 0);
  endtask

  task automatic do_start();
    step(0, 0, 1);
    m_round = 0; m_lives = NLIVES; m_hit = 0; m_over = 0;
    check_eq("start_round", round, 0);
    check_eq("start_lives", lives, NLIVES);
    check_eq("start_hit",   hit, 0);
    check_eq("start_busy",  busy, 1);
    check_eq("start_done",  done, 0);
  endtask

  // Entered with the DUT in ARM; leaves it in ARM again, or in OVER.
  task automatic play_round(input int n, input int tgt, input bit tos, input bit noise);
    int spd;
    int diff;
    spd = exp_speed();
    step(0, 0, 0);
    check_eq("arm_clear", current_number, 0);
    check_eq("speed",     speed_sel, spd);
    check_eq("busy_run",  busy, 1);
    for (int k = 1; k <= n; k++) begin
      step(0, 0, noise && ($urandom_range(0, 1) == 1));
      step(0, 0, 0);
      step(1, 0, 0);
      check_eq("count", current_number, k % (MAXC + 1));
    end
    step(0, 0, 0);
    m_cap = n % (MAXC + 1);
    step(tos, 1, noise);
    check_eq("captured",   captured, m_cap);
    check_eq("stop_hold",  current_number, m_cap);
    target = 7'(tgt);
    step(0, 0, 0);
    diff  = (m_cap > tgt) ? m_cap - tgt : tgt - m_cap;
    m_hit = (diff <= TOL);
    if (m_hit) begin
      m_round++;
      if (m_round == NROUND) begin m_over = 1; m_win = 1; end
    end else begin
      m_lives--;
      if (m_lives == 0) begin m_over = 1; m_win = 0; end
    end
    check_eq("hit",   hit, m_hit);
    check_eq("round", round, m_round);
    check_eq("lives", lives, m_lives);
    check_eq("done",  done, m_over);
    check_eq("busy",  busy, !m_over);
    if (m_over) check_eq("win", win, m_win);
    if (!m_over) begin
      for (int i = 1; i <= RCYC; i++) begin
        step(i % 2 == 1, noise && (i == 2), 0);
        check_eq("result_frozen", current_number, m_cap);
        check_eq("result_speed",  speed_sel, spd);
        check_eq("result_busy",   busy, 1);
      end
    end
  endtask

  task automatic over_checks();
    step(1, 1, 0);
    step(1, 0, 0);
    check_eq("over_done",   done, 1);
    check_eq("over_busy",   busy, 0);
    check_eq("over_win",    win, m_win);
    check_eq("over_lives",  lives, m_lives);
    check_eq("over_round",  round, m_round);
    check_eq("over_capt",   captured, m_cap);
    check_eq("over_number", current_number, m_cap);
    check_eq("over_speed",  speed_sel, 1);
    check_eq("over_hit",    hit, m_hit);
  endtask

  initial begin
    int n, cap, tgt, guard;
    reset = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    reset = 1'b0;
    step(0, 0, 0);
    check_reset_vals();
    step(1, 1, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_capt", captured, 0);

    // Game 1: a hit, then three misses (one with a wrapped counter) ends in a loss.
    do_start();
    play_round(5, 5, 0, 0);
    play_round(11, 9, 0, 0);
    play_round(3, 20, 0, 0);
    play_round(4, 0, 0, 0);
    check_eq("lose_win", win, 0);
    over_checks();

    // Game 2: tolerance edges and a coincident tick/stop, ending in a win.
    do_start();
    play_round(6, 8, 0, 0);
    play_round(9, 7, 0, 0);
    play_round(13, 5, 0, 0);
    play_round(7, 7, 1, 0);
    play_round(20, 8, 0, 1);
    check_eq("win_flag", win, 1);
    over_checks();

    // Game 3: randomized rounds until the game ends.
    do_start();
    guard = 0;
    while (!m_over && guard < 20) begin
      guard++;
      n   = $urandom_range(0, 24);
      cap = n % (MAXC + 1);
      case ($urandom_range(0, 3))
        0: tgt = cap + $urandom_range(0, TOL);
        1: tgt = cap - $urandom_range(0, TOL);
        2: tgt = $urandom_range(0, 127);
        default: tgt = ($urandom_range(0, 1) == 1) ? cap + TOL + 1 : cap - TOL - 1;
      endcase
      if (tgt < 0) tgt = 0;
      play_round(n, tgt, $urandom_range(0, 1) == 1, 1);
    end
    check_eq("rand_ended", m_over, 1);
    over_checks();

    // Reset in the middle of a round abandons it.
    do_start();
    step(0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0);
      step(0, 0, 0);
      step(1, 0, 0);
      check_eq("pre_rst_count", current_number, k);
    end
    reset = 1'b1;
    step(0, 0, 0);
    check_reset_vals();
    reset = 1'b0;
    step(0, 0, 0);
    check_eq("post_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
